psa_pipe_stage: RTL and testbench



---
 rtl/psa_pipe_stage.sv | 114 +++++++++++
 tb/tb_psa_pipe_stage.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psa_pipe_stage.sv
// Two-stage packed sub-word add/subtract unit for EX.
// S1 holds operands, S2 holds lane results, flags and valid.
module psa_pipe_stage #(
  parameter int LANES    = 4,
  parameter int LANE_W   = 4,
  parameter int SATURATE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_a,
  input  logic [LANES*LANE_W-1:0] in_b,
  input  logic                    in_sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_sum,
  output logic [LANES-1:0]        out_lane_ovfl,
  output logic                    out_err,
  input  logic                    clr_sticky,
  output logic                    sticky_err
);

  localparam int W = LANES * LANE_W;
  localparam logic [LANE_W-1:0] LMIN = {1'b1, {(LANE_W-1){1'b0}}};
  localparam logic [LANE_W-1:0] LMAX = ~LMIN;

  logic             s1_valid;
  logic [W-1:0]     s1_a;
  logic [W-1:0]     s1_b;
  logic             s1_sub;
  logic             s1_adv;
  logic             s2_adv;
  logic             take;
  logic [W-1:0]     sum_c;
  logic [LANES-1:0] ovfl_c;
  logic [LANE_W-1:0] a_l;
  logic [LANE_W-1:0] b_l;
  logic [LANE_W-1:0] r_l;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv & !flush & !rst;
  assign take     = in_valid & in_ready;

  // Each lane is an independent adder; subtraction is ~b plus carry-in.
  always_comb begin
    sum_c  = '0;
    ovfl_c = '0;
    a_l    = '0;
    b_l    = '0;
    r_l    = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l = s1_a[i*LANE_W +: LANE_W];
      b_l = s1_sub ? ~s1_b[i*LANE_W +: LANE_W]
                   : s1_b[i*LANE_W +: LANE_W];
      r_l = a_l + b_l + {{(LANE_W-1){1'b0}}, s1_sub};
      ovfl_c[i] = (a_l[LANE_W-1] == b_l[LANE_W-1])
                & (r_l[LANE_W-1] != a_l[LANE_W-1]);
      if (SATURATE != 0 && ovfl_c[i])
        sum_c[i*LANE_W +: LANE_W] = a_l[LANE_W-1] ? LMIN : LMAX;
      else
        sum_c[i*LANE_W +: LANE_W] = r_l;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= take;
      if (take) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_sub <= in_sub;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_sum       <= '0;
      out_lane_ovfl <= '0;
      out_err       <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sum       <= sum_c;
        out_lane_ovfl <= ovfl_c;
        out_err       <= |ovfl_c;
      end
    end
  end

  // A handshake in the flush cycle is still a delivery; set beats clear.
  always_ff @(posedge clk) begin
    if (rst)
      sticky_err <= 1'b0;
    else if (out_valid & out_ready & out_err)
      sticky_err <= 1'b1;
    else if (clr_sticky)
      sticky_err <= 1'b0;
  end

endmodule

// File: tb/tb_psa_pipe_stage.sv
// Directed bench for psa_pipe_stage, saturating and wrapping builds.
// Inputs change on the falling edge; outputs are read there too.
module tb_psa_pipe_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_sub;
  logic        out_ready;
  logic        clr_sticky;

  logic        in_ready, w_in_ready;
  logic        out_valid, w_out_valid;
  logic [15:0] out_sum, w_out_sum;
  logic [3:0]  ovfl, w_ovfl;
  logic        out_err, w_out_err;
  logic        sticky, w_sticky;

  int vecs;
  int errs;

  psa_pipe_stage #(.LANES(4), .LANE_W(4), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_lane_ovfl(ovfl), .out_err(out_err),
    .clr_sticky(clr_sticky), .sticky_err(sticky)
  );

  psa_pipe_stage #(.LANES(4), .LANE_W(4), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_sum(w_out_sum), .out_lane_ovfl(w_ovfl), .out_err(w_out_err),
    .clr_sticky(clr_sticky), .sticky_err(w_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One op into an empty pipe; returns when the result is on the output.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic s);
    in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk); #1;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL rst_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vecs++;
    if ({in_ready, out_valid, out_sum, ovfl, out_err, sticky} !==
        {1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 1'b0}) begin
      errs++;
      $display("FAIL reset_state: rdy=%b v=%b s=%h o=%h e=%b st=%b want 1 0 0000 0 0 0",
               in_ready, out_valid, out_sum, ovfl, out_err, sticky);
    end
  endtask

  task automatic test_basic_add;
    out_ready = 1'b1;
    issue(16'h1234, 16'h1111, 1'b0);
    vecs++;
    if ({out_valid, out_sum, ovfl, out_err} !== {1'b1, 16'h2345, 4'h0, 1'b0}) begin
      errs++;
      $display("FAIL basic_add: v=%b s=%h o=%h e=%b want 1 2345 0 0",
               out_valid, out_sum, ovfl, out_err);
    end
    @(negedge clk); #1;
    vecs++;
    if ({out_valid, sticky} !== 2'b00) begin
      errs++; $display("FAIL basic_after: v=%b st=%b want 0 0", out_valid, sticky);
    end
  endtask

  task automatic test_sat_add;
    issue(16'h7777, 16'h1111, 1'b0);
    vecs++;
    if ({out_valid, out_sum, ovfl, out_err} !== {1'b1, 16'h7777, 4'hF, 1'b1}) begin
      errs++;
      $display("FAIL sat_add: v=%b s=%h o=%h e=%b want 1 7777 f 1",
               out_valid, out_sum, ovfl, out_err);
    end
    vecs++;
    if ({w_out_sum, w_ovfl} !== {16'h8888, 4'hF}) begin
      errs++; $display("FAIL wrap_add: s=%h o=%h want 8888 f", w_out_sum, w_ovfl);
    end
    vecs++;
    if (sticky !== 1'b0) begin
      errs++; $display("FAIL sticky_early: got %b want 0", sticky);
    end
    @(negedge clk); #1;
    vecs++;
    if (sticky !== 1'b1) begin
      errs++; $display("FAIL sticky_set: got %b want 1", sticky);
    end
    clr_sticky = 1'b1;
    @(negedge clk); #1;
    clr_sticky = 1'b0;
    vecs++;
    if (sticky !== 1'b0) begin
      errs++; $display("FAIL sticky_clr: got %b want 0", sticky);
    end
  endtask

  task automatic test_sat_sub;
    issue(16'h8000, 16'h1000, 1'b1);
    vecs++;
    if ({out_sum, ovfl, out_err} !== {16'h8000, 4'h8, 1'b1}) begin
      errs++;
      $display("FAIL sat_sub: s=%h o=%h e=%b want 8000 8 1", out_sum, ovfl, out_err);
    end
    vecs++;
    if ({w_out_sum, w_ovfl} !== {16'h7000, 4'h8}) begin
      errs++; $display("FAIL wrap_sub: s=%h o=%h want 7000 8", w_out_sum, w_ovfl);
    end
    @(negedge clk);
    issue(16'h0003, 16'h0005, 1'b1);
    vecs++;
    if ({out_sum, ovfl, out_err, w_out_sum} !== {16'h000E, 4'h0, 1'b0, 16'h000E}) begin
      errs++;
      $display("FAIL sub_neg: s=%h o=%h e=%b ws=%h want 000e 0 0 000e",
               out_sum, ovfl, out_err, w_out_sum);
    end
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] oa [4] = '{16'h1234, 16'h7777, 16'h0003, 16'h4321};
    logic [15:0] ob [4] = '{16'h1111, 16'h1111, 16'h0005, 16'h0101};
    logic        os [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] es [4] = '{16'h2345, 16'h7777, 16'h000E, 16'h4220};
    logic [3:0]  eo [4] = '{4'h0, 4'hF, 4'h0, 4'h0};
    int acc = 0;
    int del = 0;
    logic stalled = 1'b0;
    logic [15:0] ps = '0;
    logic [3:0]  po = '0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      in_valid = (acc < 4);
      if (acc < 4) begin
        in_a = oa[acc]; in_b = ob[acc]; in_sub = os[acc];
      end
      #1;
      if (out_valid && !out_ready) begin
        vecs++;
        if (in_ready !== ((acc - del) < 2)) begin
          errs++;
          $display("FAIL bp_in_ready c%0d: got %b want %b", c, in_ready,
                   ((acc - del) < 2));
        end
        if (stalled) begin
          vecs++;
          if ({out_sum, ovfl} !== {ps, po}) begin
            errs++;
            $display("FAIL bp_stable c%0d: s=%h o=%h want %h %h", c, out_sum, ovfl, ps, po);
          end
        end
        stalled = 1'b1; ps = out_sum; po = ovfl;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        vecs++;
        if (del >= 4) begin
          errs++; $display("FAIL bp_extra: got result %h want none", out_sum);
        end else if ({out_sum, ovfl} !== {es[del], eo[del]}) begin
          errs++;
          $display("FAIL bp_order%0d: s=%h o=%h want %h %h", del, out_sum, ovfl,
                   es[del], eo[del]);
        end
        del++;
      end
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vecs++;
    if (del !== 4) begin
      errs++; $display("FAIL bp_count: got %0d results want 4", del);
    end
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
  endtask

  task automatic test_flush;
    out_ready = 1'b1;
    in_a = 16'h7777; in_b = 16'h1111; in_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    vecs++;
    if ({out_valid, w_out_valid} !== 2'b00) begin
      errs++; $display("FAIL flush_valid: got %b%b want 00", out_valid, w_out_valid);
    end
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if ({out_valid, sticky} !== 2'b00) begin
      errs++; $display("FAIL flush_ghost: v=%b st=%b want 0 0", out_valid, sticky);
    end
  endtask

  task automatic test_sticky_reset;
    issue(16'h7777, 16'h1111, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    vecs++;
    if ({sticky, out_valid, in_ready} !== 3'b110) begin
      errs++;
      $display("FAIL rst_setup: st=%b v=%b rdy=%b want 1 1 0", sticky, out_valid, in_ready);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    vecs++;
    if ({out_valid, sticky, out_sum} !== {1'b0, 1'b0, 16'h0}) begin
      errs++;
      $display("FAIL rst_mid: v=%b st=%b s=%h want 0 0 0000", out_valid, sticky, out_sum);
    end
    repeat (3) @(negedge clk);
    #1;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL rst_ghost: got %b want 0", out_valid);
    end
    issue(16'h7777, 16'h1111, 1'b0);
    clr_sticky = 1'b1;
    @(negedge clk);
    #1;
    vecs++;
    if (sticky !== 1'b1) begin
      errs++; $display("FAIL set_wins: got %b want 1", sticky);
    end
    @(negedge clk);
    clr_sticky = 1'b0;
    #1;
    vecs++;
    if (sticky !== 1'b0) begin
      errs++; $display("FAIL clr_alone: got %b want 0", sticky);
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; in_sub = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic_add;
    test_sat_add;
    test_sat_sub;
    test_back_to_back;
    test_flush;
    test_sticky_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
